if_prefetch_queue: RTL and testbench

//  Instruction prefetch buffer between IF (PC register + instruction ROM) and the issue register.

---
 rtl/if_prefetch_queue.sv | 89 ++++++++
 tb/tb_if_prefetch_queue.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: fetches one word per cycle from a combinational ROM
// into a small FIFO of {pc, inst} pairs that issue drains independently.
module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 7,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [ADDR_W-1:0]          rom_addr,
    input  logic [31:0]                rom_data,
    input  logic                       flush,
    input  logic [31:0]                flush_pc,
    input  logic                       deq_en,
    output logic                       out_valid,
    output logic [31:0]                out_inst,
    output logic [31:0]                out_pc,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [31:0]      NOP_INST   = 32'h0000_0013;

    logic [31:0]      fetch_pc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_next;
    logic [31:0]      pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];
    logic             enq;
    logic             deq;

    assign rom_addr  = fetch_pc[ADDR_W+1:2];

    assign empty     = (count == '0);
    assign full      = (count == FULL_COUNT);
    assign out_valid = !empty;
    assign out_inst  = empty ? NOP_INST : inst_mem[rd_ptr];
    assign out_pc    = empty ? 32'h0    : pc_mem[rd_ptr];

    // A full queue that is being drained this cycle still accepts the next fetch.
    assign deq = deq_en && out_valid;
    assign enq = !flush && (!full || deq);

    always_comb begin
        count_next = count;
        if (enq && !deq) begin
            count_next = count + CNT_W'(1);
        end else if (!enq && deq) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            inst_mem[wr_ptr] <= rom_data;
        end
    end

    // Redirect clears the queue outright, so any head consumed alongside it needs no pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC & 32'hFFFF_FFFC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (flush) begin
            fetch_pc <= flush_pc & 32'hFFFF_FFFC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (enq) begin
                fetch_pc <= fetch_pc + 32'd4;
                wr_ptr   <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
        end
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue with a model ROM where ROM[i] = i+1.
module tb_if_prefetch_queue;

    logic        clk;
    logic        rst;
    logic [6:0]  rom_addr;
    logic [31:0] rom_data;
    logic        flush;
    logic [31:0] flush_pc;
    logic        deq_en;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        full;
    logic        empty;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    if_prefetch_queue #(.DEPTH(4), .ADDR_W(7), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
        .flush(flush), .flush_pc(flush_pc), .deq_en(deq_en),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
        .full(full), .empty(empty), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rom_data = {25'b0, rom_addr} + 32'd1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_pc;
        int          mcount;
        logic        mdeq;
        logic        menq;

        rst = 1'b1; flush = 1'b0; flush_pc = 32'h0; deq_en = 1'b0;
        step();
        step();
        check("reset_valid", {31'b0, out_valid}, 32'd0);
        check("reset_empty", {31'b0, empty}, 32'd1);
        check("reset_full", {31'b0, full}, 32'd0);
        check("reset_inst", out_inst, 32'h13);
        check("reset_pc", out_pc, 32'h0);
        check("reset_count", {29'b0, count}, 32'd0);
        check("reset_addr", {25'b0, rom_addr}, 32'd0);

        $display("[TB] fill with no dequeue");
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("fill_count", {29'b0, count}, (k < 4) ? k : 4);
            check("fill_full", {31'b0, full}, (k >= 4) ? 32'd1 : 32'd0);
            check("fill_head_pc", out_pc, 32'h0);
            check("fill_head_inst", out_inst, 32'd1);
        end
        check("fill_fetch_hold", {25'b0, rom_addr}, 32'd4);

        $display("[TB] dequeue from full");
        deq_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_pc", out_pc, 32'(4 * i));
            check("drain_inst", out_inst, 32'(i + 1));
            check("drain_count", {29'b0, count}, 32'd4);
            check("drain_full", {31'b0, full}, 32'd1);
            step();
        end
        check("drain_after_pc", out_pc, 32'h20);

        $display("[TB] flush with concurrent dequeue");
        deq_en = 1'b0; flush = 1'b1; flush_pc = 32'h100;
        step();
        check("flush1_empty", {31'b0, empty}, 32'd1);
        flush = 1'b0;
        step(); step(); step();
        check("pre_flush_count", {29'b0, count}, 32'd3);
        check("pre_flush_head", out_pc, 32'h100);
        check("pre_flush_inst", out_inst, 32'd65);
        flush = 1'b1; flush_pc = 32'h40; deq_en = 1'b1;
        step();
        check("flush2_empty", {31'b0, empty}, 32'd1);
        check("flush2_inst", out_inst, 32'h13);
        check("flush2_pc", out_pc, 32'h0);
        check("flush2_addr", {25'b0, rom_addr}, 32'h10);
        flush = 1'b0; deq_en = 1'b0;
        step();
        check("flush2_first_pc", out_pc, 32'h40);
        check("flush2_first_inst", out_inst, 32'd17);
        check("flush2_first_count", {29'b0, count}, 32'd1);

        $display("[TB] reset overrides flush");
        step();
        check("pre_reset_count", {29'b0, count}, 32'd2);
        rst = 1'b1; flush = 1'b1; flush_pc = 32'h80;
        step();
        check("rst_flush_count", {29'b0, count}, 32'd0);
        check("rst_flush_empty", {31'b0, empty}, 32'd1);
        check("rst_flush_addr", {25'b0, rom_addr}, 32'd0);
        rst = 1'b0; flush = 1'b0;
        step();
        check("rst_flush_first_pc", out_pc, 32'h0);
        check("rst_flush_first_inst", out_inst, 32'd1);

        $display("[TB] alternating dequeue from reset");
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_pc = 32'h0;
        mcount = 0;
        for (int i = 0; i < 16; i++) begin
            deq_en = (i % 2 == 0);
            mdeq = deq_en && (mcount > 0);
            menq = (mcount < 4) || mdeq;
            if (mdeq) begin
                check("alt_pc", out_pc, exp_pc);
                check("alt_inst", out_inst, (exp_pc >> 2) + 32'd1);
                exp_pc = exp_pc + 32'd4;
            end
            step();
            mcount = mcount + (menq ? 1 : 0) - (mdeq ? 1 : 0);
            check("alt_count", {29'b0, count}, 32'(mcount));
            checks++;
            assert (count <= 3'd4) else begin
                errors++;
                $error("[TB] FAIL alt_count_bound: observed %0d expected <= 4", count);
            end
        end
        deq_en = 1'b0;

        $display("[TB] fetch pc wrap");
        flush = 1'b1; flush_pc = 32'hFFFF_FFFE;
        step();
        flush = 1'b0;
        check("wrap_addr_top", {25'b0, rom_addr}, 32'h7F);
        check("wrap_empty", {31'b0, empty}, 32'd1);
        step();
        check("wrap_head_pc", out_pc, 32'hFFFF_FFFC);
        check("wrap_head_inst", out_inst, 32'h80);
        check("wrap_addr_zero", {25'b0, rom_addr}, 32'd0);
        check("wrap_count1", {29'b0, count}, 32'd1);
        step();
        check("wrap_addr_one", {25'b0, rom_addr}, 32'd1);
        check("wrap_count2", {29'b0, count}, 32'd2);
        deq_en = 1'b1;
        step();
        check("wrap_next_pc", out_pc, 32'h0);
        check("wrap_next_inst", out_inst, 32'd1);
        deq_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
